// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM memory bus arbiter.
// Optional build macro: MEM_ARB_RR_EN (round-robin arbitration instead of fixed priority).
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Wide enough for any legal STARVE_MAX (1..15)
    localparam int STARVE_CNT_W = 4;

    // Byte-enable "all lanes" source; sliced down to N_DATA/8 by the user
    localparam int BE_MAX_W = 128;
    localparam logic [BE_MAX_W-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the IF and DM requesters.
// Optional build macro: MEM_ARB_RR_EN (round-robin on last owner instead of
// DM priority with an IF starvation limit).
module mem_arb_pick
    import mem_arb_pkg::*;
`ifndef MEM_ARB_RR_EN
#(
    parameter int STARVE_MAX = 2
)
`endif
(
    input  logic                    if_req,
    input  logic                    dm_req,
`ifdef MEM_ARB_RR_EN
    input  owner_t                  last_owner,
`else
    input  logic [STARVE_CNT_W-1:0] starve_cnt,
`endif
    output owner_t                  winner,
    output logic                    grant_valid
);

    // Pick a winner; a lone requester always wins, conflicts use the arbitration policy
    always_comb begin
        grant_valid = if_req | dm_req;
        winner      = OWN_IF;
        if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
            winner = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
`else
            winner = (starve_cnt == STARVE_CNT_W'(STARVE_MAX)) ? OWN_IF : OWN_DM;
`endif
        end else if (dm_req) begin
            winner = OWN_DM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch (IF) and data (DM).
// One access in flight at a time; request fields are registered in IDLE and
// held on the memory side until i_mem_ready.
// Optional build macro: MEM_ARB_RR_EN (round-robin arbitration).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_ADDR     = 32,
    parameter int N_DATA     = 32,
    parameter int STARVE_MAX = 2
)
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_if_req,
    input  logic [N_ADDR-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [N_DATA-1:0]   o_if_rdata,
    input  logic                i_dm_req,
    input  logic                i_dm_we,
    input  logic [N_ADDR-1:0]   i_dm_addr,
    input  logic [N_DATA-1:0]   i_dm_wdata,
    input  logic [N_DATA/8-1:0] i_dm_be,
    output logic                o_dm_gnt,
    output logic                o_dm_rvalid,
    output logic [N_DATA-1:0]   o_dm_rdata,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [N_ADDR-1:0]   o_mem_addr,
    output logic [N_DATA-1:0]   o_mem_wdata,
    output logic [N_DATA/8-1:0] o_mem_be,
    input  logic                i_mem_ready,
    input  logic [N_DATA-1:0]   i_mem_rdata,
    output logic                o_busy
);

    state_t              state;
    state_t              state_next;
    owner_t              owner;
    owner_t              winner;
    logic                grant_valid;
    logic                mem_we;
    logic [N_ADDR-1:0]   mem_addr;
    logic [N_DATA-1:0]   mem_wdata;
    logic [N_DATA/8-1:0] mem_be;
    logic                if_gnt;
    logic                dm_gnt;
    logic                if_rvalid;
    logic                dm_rvalid;
    logic [N_DATA-1:0]   if_rdata;
    logic [N_DATA-1:0]   dm_rdata;

`ifdef MEM_ARB_RR_EN
    owner_t last_owner;

    mem_arb_pick u_pick (
        .if_req      (i_if_req),
        .dm_req      (i_dm_req),
        .last_owner  (last_owner),
        .winner      (winner),
        .grant_valid (grant_valid)
    );

    // Remember who was granted last so the other side wins the next conflict
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_owner <= OWN_DM;
        end else if (state == IDLE && grant_valid) begin
            last_owner <= winner;
        end
    end
`else
    logic [STARVE_CNT_W-1:0] starve_cnt;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .if_req      (i_if_req),
        .dm_req      (i_dm_req),
        .starve_cnt  (starve_cnt),
        .winner      (winner),
        .grant_valid (grant_valid)
    );

    // Count conflicts IF has lost in a row; cleared when IF wins or stops asking
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!i_if_req || (grant_valid && winner == OWN_IF)) begin
                starve_cnt <= '0;
            end else if (i_dm_req && starve_cnt != STARVE_CNT_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start an access on any grant, finish it on memory ready
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ACCESS;
            ACCESS:  if (i_mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the winner's request, pulse gnt/rvalid, and route read data to the owner
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            owner     <= OWN_IF;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if (state == IDLE && grant_valid) begin
                owner <= winner;
                if (winner == OWN_DM) begin
                    mem_we    <= i_dm_we;
                    mem_addr  <= i_dm_addr;
                    mem_wdata <= i_dm_wdata;
                    mem_be    <= i_dm_be;
                    dm_gnt    <= 1'b1;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= i_if_addr;
                    mem_wdata <= '0;
                    mem_be    <= BE_ALL_ONES[N_DATA/8-1:0];
                    if_gnt    <= 1'b1;
                end
            end
            if (state == ACCESS && i_mem_ready && !mem_we) begin
                if (owner == OWN_IF) begin
                    if_rdata  <= i_mem_rdata;
                    if_rvalid <= 1'b1;
                end else begin
                    dm_rdata  <= i_mem_rdata;
                    dm_rvalid <= 1'b1;
                end
            end
        end
    end

    assign o_busy      = (state == ACCESS);
    assign o_mem_req   = (state == ACCESS);
    assign o_mem_we    = (state == ACCESS) & mem_we;
    assign o_mem_addr  = mem_addr;
    assign o_mem_wdata = mem_wdata;
    assign o_mem_be    = mem_be;
    assign o_if_gnt    = if_gnt;
    assign o_dm_gnt    = dm_gnt;
    assign o_if_rvalid = if_rvalid;
    assign o_dm_rvalid = dm_rvalid;
    assign o_if_rdata  = if_rdata;
    assign o_dm_rdata  = dm_rdata;

endmodule
